// File: rtl/tdc_pkg.sv
// tdc_pkg
// Shared definitions for the TDC fine-time decoder slice.
//   FINE_W       : width of the encoded fine code
//   SNAP_W       : width of the delay-line snapshot
//   DEF_COARSE_W : default coarse counter width used by tdc_ts_t
//   tdc_fine_t   : {err, polarity, fine}, the encoder result
//   tdc_ts_t     : {err, polarity, fine, coarse}, a complete timestamp
//   maj3()       : 3-input majority vote used for bubble correction
package tdc_pkg;

  localparam int FINE_W       = 5;
  localparam int SNAP_W       = 32;
  localparam int DEF_COARSE_W = 16;

  typedef struct packed {
    logic              err;
    logic              polarity;
    logic [FINE_W-1:0] fine;
  } tdc_fine_t;

  typedef struct packed {
    logic                    err;
    logic                    polarity;
    logic [FINE_W-1:0]       fine;
    logic [DEF_COARSE_W-1:0] coarse;
  } tdc_ts_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tdc_fine_decoder_if.sv
// tdc_fine_decoder_if
// Timestamp stream carrying decoded hits to the readout logic.
//   ts_data  : {err, polarity, fine[4:0], coarse}
//   ts_valid : head entry is valid
//   ts_ready : consumer accepts the head entry when ts_valid is high
// The decoder uses the master modport, the consumer the slave modport.
interface tdc_fine_decoder_if #(
  parameter int COARSE_W = 16
);
  import tdc_pkg::*;

  logic [COARSE_W+FINE_W+1:0] ts_data;
  logic                       ts_valid;
  logic                       ts_ready;

  modport master (
    output ts_data,
    output ts_valid,
    input  ts_ready
  );

  modport slave (
    input  ts_data,
    input  ts_valid,
    output ts_ready
  );

endinterface

// File: rtl/tdc_sync_fifo.sv
// tdc_sync_fifo
// Synchronous first-word-fall-through FIFO.
//   clk, rst : clock and synchronous active-high reset (clears pointers)
//   push     : write wdata if there is room (or a pop frees a slot this cycle)
//   wdata    : entry to write
//   pop      : remove the head entry if not empty
//   rdata    : head entry, reads 0 while empty
//   full     : all DEPTH slots occupied
//   empty    : no entries stored
module tdc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tdc_fine_decoder.sv
// tdc_fine_decoder
// Decodes the 32-bit delay-line snapshot of the TDC fine-time bit into a
// timestamp {err, polarity, fine, coarse} and buffers it in an output FIFO.
//   clk, rst : system clock, synchronous active-high reset
//   hit_stb  : one-cycle pulse, snap is stable and synchronized
//   snap     : fine-time snapshot, bit 4k+p = stage k of phase p
//   ts       : timestamp stream (master side), data/valid/ready
//   overflow : sticky, a hit was dropped because the FIFO was full
//   drop_cnt : saturating count of dropped hits
//   coarse   : free-running coarse counter
// Pipeline: S1 capture -> S2 bubble correction -> S3 encode -> FIFO write.
module tdc_fine_decoder
  import tdc_pkg::*;
#(
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hit_stb,
  input  logic [SNAP_W-1:0]   snap,
  tdc_fine_decoder_if.master  ts,
  output logic                overflow,
  output logic [7:0]          drop_cnt,
  output logic [COARSE_W-1:0] coarse
);

  localparam int TS_W = COARSE_W + FINE_W + 2;

  logic [SNAP_W-1:0]   s1_snap;
  logic [COARSE_W-1:0] s1_coarse;
  logic                v1;

  logic [SNAP_W+1:0]   s1_ext;
  logic [SNAP_W-1:0]   therm;
  logic [SNAP_W-1:0]   s2_therm;
  logic [COARSE_W-1:0] s2_coarse;
  logic                v2;

  tdc_fine_t           enc;
  logic                found;
  logic                multi;
  tdc_fine_t           s3_fine;
  logic [COARSE_W-1:0] s3_coarse;
  logic                v3;

  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;
  logic [TS_W-1:0]     fifo_wdata;

  always_ff @(posedge clk) begin
    if (rst) coarse <= '0;
    else     coarse <= coarse + COARSE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else begin
      v1 <= hit_stb;
      if (hit_stb) begin
        s1_snap   <= snap;
        s1_coarse <= coarse;
      end
    end
  end

  // Edge stages replicate themselves, so s1_ext[i] is s[i-1] with
  // s[-1]=s[0] and s[32]=s[31].
  assign s1_ext = {s1_snap[SNAP_W-1], s1_snap, s1_snap[0]};

  always_comb begin
    therm = '0;
    for (int i = 0; i < SNAP_W; i++) begin
      therm[i] = maj3(s1_ext[i], s1_ext[i+1], s1_ext[i+2]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2_therm  <= therm;
        s2_coarse <= s1_coarse;
      end
    end
  end

  // The first adjacent difference is the first index differing from t[0];
  // a second one means the corrected pattern is still not a clean edge.
  always_comb begin
    found        = 1'b0;
    multi        = 1'b0;
    enc.fine     = '1;
    enc.polarity = s2_therm[0];
    for (int i = 1; i < SNAP_W; i++) begin
      if (s2_therm[i] != s2_therm[i-1]) begin
        if (!found) enc.fine = FINE_W'(i - 1);
        else        multi    = 1'b1;
        found = 1'b1;
      end
    end
    enc.err = !found || multi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
    end else begin
      v3 <= v2;
      if (v2) begin
        s3_fine   <= enc;
        s3_coarse <= s2_coarse;
      end
    end
  end

  assign fifo_wdata = {s3_fine, s3_coarse};
  assign pop        = ts.ts_ready && !fifo_empty;
  assign drop       = v3 && fifo_full && !pop;

  tdc_sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v3),
    .wdata (fifo_wdata),
    .pop   (ts.ts_ready),
    .rdata (ts.ts_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ts.ts_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
